sr_flag_file: RTL

Parametrised, clocked successor to the cross-coupled SR latch: a bank of DEPTH entries, each WIDTH independent SR flag bits, updated synchronously through per-bit set/reset masks. Set/reset conflicts are resolved by a compile-time priority parameter and reported. The block gives the processor a status/flag store (condition flags, interrupt-pending bits) with a combinational read port and registered event outputs.

---
 rtl/sr_flag_file.sv | 92 +++++++++
 1 files changed

// File: rtl/sr_flag_file.sv
// Bank of DEPTH x WIDTH synchronous SR flags with masked set/reset, edge pulses and conflict flag.
// Optional saturating conflict counter enabled by defining SR_FLAG_CONFLICT_COUNT_EN.
module sr_flag_file #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 8,
   parameter bit          SET_DOMINANT = 1'b1,
   parameter int unsigned AW           = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] setmask,
   input  logic [WIDTH-1:0] rstmask,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             conflict,
   output logic [DEPTH-1:0] anyset
`ifdef SR_FLAG_CONFLICT_COUNT_EN
   ,
   output logic [7:0]       conflict_cnt
`endif
);

   logic [WIDTH-1:0] flags_q [DEPTH];
   logic [WIDTH-1:0] old_w;
   logic [WIDTH-1:0] new_w;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic             conflict_q;
   logic             conflict_w;

   always_comb begin
      old_w      = flags_q[waddr];
      conflict_w = |(setmask & rstmask);
      // Overlapping bits take the dominant operation's value.
      if (SET_DOMINANT) begin
         new_w = (old_w & ~rstmask) | setmask;
      end else begin
         new_w = (old_w | setmask) & ~rstmask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            flags_q[i] <= '0;
         end
         rise_q     <= '0;
         fall_q     <= '0;
         conflict_q <= 1'b0;
      end else if (write) begin
         flags_q[waddr] <= new_w;
         rise_q         <= new_w & ~old_w;
         fall_q         <= old_w & ~new_w;
         conflict_q     <= conflict_w;
      end else begin
         rise_q     <= '0;
         fall_q     <= '0;
         conflict_q <= 1'b0;
      end
   end

`ifdef SR_FLAG_CONFLICT_COUNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (write && conflict_w && (cnt_q != 8'd255)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign conflict_cnt = cnt_q;
`endif

   always_comb begin
      anyset = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         anyset[i] = |flags_q[i];
      end
   end

   assign rdata    = flags_q[raddr];
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign conflict = conflict_q;

endmodule
